cu_fsm: RTL and testbench
=========================

Name: cu_fsm

Overview:
Parametrised multi-cycle RV32I control unit; successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Uses a valid/ready handshake with the fetch path and a request/done handshake with the LSU.
- Drives the existing datapath muxes, ALU, branch unit and register file.
- Adds registered outputs, a memory timeout, x0 write suppression and an illegal-instruction trap.

Parameters:
- XLEN, 32, instruction width; must be 32.
- RADR_W, 5, register-address width.
- TIMEOUT_W, 8, width of the MEM-wait counter; trap after 2^TIMEOUT_W-1 idle cycles.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- MEM_INST  in  XLEN  instruction word.
- INST_VALID  in  1  MEM_INST valid.
- INST_READY  out  1  CU accepts instruction (FETCH only).
- MEM_DONE  in  1  LSU access complete.
- MEM_REQ  out  1  LSU access request.
- RS1_ADR / RS2_ADR / REG_ADR  out  RADR_W  register addresses.
- ALU_OPT  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- BR_OPT  out  4  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 JAL, 5 JALR, 6 BLTU, 7 BGEU, 15 none.
- LSU_OPT  out  3  loads: funct3; stores: 5 SB, 6 SH, 7 SW.
- IMM_TYPE  out  3  0 I, 1 B, 2 S, 3 U, 4 J.
- RS1_MUX_SELECT / RS2_MUX_SELECT / REG_MUX_SELECT / LSU_MUX_SELECT / PC_MUX_SELECT  out  3  datapath mux selects, existing encodings.
- WRITE_ENB  out  1  register-file write strobe.
- MEM_WRITE_ENB  out  1  store strobe.
- PC_EN  out  1  one-cycle PC update strobe.
- TRAP  out  1  sticky fault flag.
- STATE  out  3  current state, for debug.

Behaviour:
- Reset values:
  - State FETCH.
  - All addresses, selects, LSU_OPT, IMM_TYPE, ALU_OPT = 0.
  - BR_OPT = 15.
  - All strobes, INST_READY, MEM_REQ, TRAP = 0.
  - Timeout counter = 0.
- All outputs are registered. Selects and opts hold their values from DECODE until the next DECODE.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - INST_READY=1.
  - On INST_VALID&INST_READY, latch MEM_INST into the IR and go to DECODE. Otherwise stay.
- DECODE (1 cycle): decode IR into all selects and opts.
  - Unknown opcode, or funct7 other than 0x00/0x20 on SRL/SRA/ADD/SUB, is illegal: go to TRAP.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - ALU, LUI, AUIPC, JAL, JALR go to WB.
  - Conditional branch: PC_EN=1 for 1 cycle (branch unit resolves taken/not), then FETCH.
  - Load or store: go to MEM.
- MEM:
  - MEM_REQ=1. For stores, MEM_WRITE_ENB=1 while MEM_REQ is high.
  - Timeout counter increments each cycle without MEM_DONE.
  - On MEM_DONE: drop both strobes and clear the counter. Loads go to WB; stores pulse PC_EN and go to FETCH.
  - Counter reaching 2^TIMEOUT_W-1 with no MEM_DONE: go to TRAP.
  - MEM_DONE in the same cycle as terminal count: done wins.
- WB (1 cycle):
  - WRITE_ENB=1 only if REG_ADR != 0 (x0 writes suppressed).
  - PC_EN=1; go to FETCH.
- TRAP:
  - TRAP=1, INST_READY=0, all strobes 0.
  - Exit only via RST.
- Latency from handshake accept to WRITE_ENB:
  - ALU/LUI/AUIPC/JAL/JALR: 3 cycles.
  - Load: 3 + MEM wait cycles (minimum 1).
- RST asserted mid-instruction: immediate async return to reset values. No partial write or store completes.
- INST_VALID outside FETCH is ignored.

Optional Feature:
- Macro CU_SYSTEM_NOP_EN.
- Defined: opcodes 0x0F (FENCE) and 0x73 (SYSTEM) decode as NOP. Sequence is DECODE -> EXEC -> WB with WRITE_ENB=0 and PC_EN=1.
- Undefined: these opcodes are illegal and go to TRAP.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams;
  - state encoding;
  - ALU_OPT, BR_OPT, LSU_OPT, IMM_TYPE and mux-select constants.
- Sub-module cu_decode: purely combinational IR -> control-field bundle plus illegal flag, registered by cu_fsm in DECODE.

Test Plan:
- ADDI x1,x0,5 (0x00500093), INST_VALID=1 at FETCH:
  - INST_READY high in cycle 0.
  - Cycle 3: ALU_OPT=0, RS2_MUX_SELECT=1, REG_ADR=1, WRITE_ENB=1 and PC_EN=1 for exactly 1 cycle.
  - Cycle 4: back in FETCH.
- LW x2,4(x1) (0x0040A103), MEM_DONE after 3 cycles in MEM:
  - MEM_REQ high for 3 cycles, LSU_OPT=2, REG_MUX_SELECT=1.
  - WRITE_ENB to REG_ADR=2 in the cycle after MEM_DONE.
- SW x2,8(x1) (0x0020A423) with MEM_DONE never asserted:
  - MEM_WRITE_ENB=1, LSU_OPT=7.
  - After 255 cycles, TRAP=1 and STATE=5; held until RST.
- BEQ x0,x0,+8 (0x00000463) -> BR_OPT=0, IMM_TYPE=1, PC_EN pulse in EXEC, no WRITE_ENB, FETCH next.
- ADD x0,x1,x2 (0x00208033) -> full sequence runs but WRITE_ENB stays 0. Then 0x00000000 -> TRAP=1.
- FENCE (0x0000000F):
  - With CU_SYSTEM_NOP_EN: PC_EN pulse, no TRAP.
  - Without it: TRAP=1.
  - In either build, RST asserted during MEM clears TRAP and returns STATE=0 asynchronously.

Source files
------------

// File: rtl/cu_pkg.sv
// Purpose : shared constants and the decoded control bundle for the multi-cycle RV32I control unit.
// Latency : n/a (definitions only).
// Backpr. : n/a.
//
// Mux-select encodings (datapath side):
//   RS1_MUX : 0 rs1 register, 1 PC, 2 zero
//   RS2_MUX : 0 rs2 register, 1 immediate
//   REG_MUX : 0 ALU result, 1 LSU load data, 2 PC+4
//   LSU_MUX : 0 idle, 1 load (address from ALU), 2 store (address from ALU, data from rs2)
//   PC_MUX  : 0 PC+4, 1 branch target (taken decided by branch unit), 2 JAL target, 3 JALR target
package cu_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    // FSM state encoding (also visible on the STATE debug port)
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BLT  = 4'd2;
    localparam logic [3:0] BR_BGE  = 4'd3;
    localparam logic [3:0] BR_JAL  = 4'd4;
    localparam logic [3:0] BR_JALR = 4'd5;
    localparam logic [3:0] BR_BLTU = 4'd6;
    localparam logic [3:0] BR_BGEU = 4'd7;
    localparam logic [3:0] BR_NONE = 4'd15;

    localparam logic [2:0] LSU_SB = 3'd5;
    localparam logic [2:0] LSU_SH = 3'd6;
    localparam logic [2:0] LSU_SW = 3'd7;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] RS1_REG  = 3'd0;
    localparam logic [2:0] RS1_PC   = 3'd1;
    localparam logic [2:0] RS1_ZERO = 3'd2;
    localparam logic [2:0] RS2_REG  = 3'd0;
    localparam logic [2:0] RS2_IMM  = 3'd1;
    localparam logic [2:0] REG_ALU  = 3'd0;
    localparam logic [2:0] REG_LSU  = 3'd1;
    localparam logic [2:0] REG_PC4  = 3'd2;
    localparam logic [2:0] LSUM_IDLE  = 3'd0;
    localparam logic [2:0] LSUM_LOAD  = 3'd1;
    localparam logic [2:0] LSUM_STORE = 3'd2;
    localparam logic [2:0] PCM_PC4  = 3'd0;
    localparam logic [2:0] PCM_BR   = 3'd1;
    localparam logic [2:0] PCM_JAL  = 3'd2;
    localparam logic [2:0] PCM_JALR = 3'd3;

    // Sequencing class chosen in DECODE, consumed by EXEC/MEM
    localparam logic [1:0] KIND_WB = 2'd0;   // ALU, LUI, AUIPC, JAL, JALR, NOP
    localparam logic [1:0] KIND_BR = 2'd1;   // conditional branch
    localparam logic [1:0] KIND_LD = 2'd2;
    localparam logic [1:0] KIND_ST = 2'd3;

    typedef struct packed {
        logic [4:0] rs1_adr;
        logic [4:0] rs2_adr;
        logic [4:0] reg_adr;
        logic [3:0] alu_opt;
        logic [3:0] br_opt;
        logic [2:0] lsu_opt;
        logic [2:0] imm_type;
        logic [2:0] rs1_mux;
        logic [2:0] rs2_mux;
        logic [2:0] reg_mux;
        logic [2:0] lsu_mux;
        logic [2:0] pc_mux;
        logic [1:0] kind;
    } cu_ctrl_t;

    // funct3 (+ funct7[5] for SUB/SRA) -> ALU_OPT
    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch funct3 -> BR_OPT; the reserved funct3 values 2/3 leave the branch unit idle
    function automatic logic [3:0] br_map(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'd0:    op = BR_BEQ;
            3'd1:    op = BR_BNE;
            3'd4:    op = BR_BLT;
            3'd5:    op = BR_BGE;
            3'd6:    op = BR_BLTU;
            3'd7:    op = BR_BGEU;
            default: op = BR_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Purpose : combinational RV32I decoder, IR -> control bundle plus illegal flag.
// Latency : 0 cycles (pure logic; cu_fsm registers the result in DECODE).
// Backpr. : none.
// Ports   : ir (instruction register), ctrl (decoded fields), illegal (unknown opcode / bad funct7).
// Build   : CU_SYSTEM_NOP_EN makes FENCE (0x0F) and SYSTEM (0x73) decode as NOPs instead of illegal.
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0] ir,
    output cu_ctrl_t    ctrl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];
    // Only the base/alternate funct7 encodings exist for ADD/SUB/SRL/SRA
    assign f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);

    always_comb begin
        ctrl        = '0;
        ctrl.br_opt = BR_NONE;
        ctrl.kind   = KIND_WB;
        illegal     = 1'b0;
        case (opcode)
            OPC_OP: begin
                ctrl.rs1_adr = ir[19:15];
                ctrl.rs2_adr = ir[24:20];
                ctrl.reg_adr = ir[11:7];
                ctrl.alu_opt = alu_map(f3, f7[5]);
                if (((f3 == 3'd0) || (f3 == 3'd5)) && !f7_ok)
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.rs1_adr = ir[19:15];
                ctrl.reg_adr = ir[11:7];
                ctrl.rs2_mux = RS2_IMM;
                ctrl.imm_type = IMM_I;
                // ADDI has no SUB form; only the shift-right immediate uses funct7[5]
                ctrl.alu_opt = alu_map(f3, (f3 == 3'd5) && f7[5]);
                if ((f3 == 3'd5) && !f7_ok)
                    illegal = 1'b1;
            end
            OPC_LUI: begin
                ctrl.reg_adr  = ir[11:7];
                ctrl.rs1_mux  = RS1_ZERO;
                ctrl.rs2_mux  = RS2_IMM;
                ctrl.imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_adr  = ir[11:7];
                ctrl.rs1_mux  = RS1_PC;
                ctrl.rs2_mux  = RS2_IMM;
                ctrl.imm_type = IMM_U;
            end
            OPC_JAL: begin
                ctrl.reg_adr  = ir[11:7];
                ctrl.imm_type = IMM_J;
                ctrl.br_opt   = BR_JAL;
                ctrl.pc_mux   = PCM_JAL;
                ctrl.reg_mux  = REG_PC4;
            end
            OPC_JALR: begin
                ctrl.rs1_adr  = ir[19:15];
                ctrl.reg_adr  = ir[11:7];
                ctrl.rs2_mux  = RS2_IMM;
                ctrl.imm_type = IMM_I;
                ctrl.br_opt   = BR_JALR;
                ctrl.pc_mux   = PCM_JALR;
                ctrl.reg_mux  = REG_PC4;
            end
            OPC_BRANCH: begin
                ctrl.rs1_adr  = ir[19:15];
                ctrl.rs2_adr  = ir[24:20];
                ctrl.imm_type = IMM_B;
                ctrl.br_opt   = br_map(f3);
                ctrl.pc_mux   = PCM_BR;
                ctrl.kind     = KIND_BR;
            end
            OPC_LOAD: begin
                ctrl.rs1_adr  = ir[19:15];
                ctrl.reg_adr  = ir[11:7];
                ctrl.rs2_mux  = RS2_IMM;
                ctrl.imm_type = IMM_I;
                ctrl.lsu_opt  = f3;
                ctrl.reg_mux  = REG_LSU;
                ctrl.lsu_mux  = LSUM_LOAD;
                ctrl.kind     = KIND_LD;
            end
            OPC_STORE: begin
                ctrl.rs1_adr  = ir[19:15];
                ctrl.rs2_adr  = ir[24:20];
                ctrl.rs2_mux  = RS2_IMM;     // ALU forms the address; store data comes via LSU mux
                ctrl.imm_type = IMM_S;
                ctrl.lsu_mux  = LSUM_STORE;
                ctrl.kind     = KIND_ST;
                case (f3)
                    3'd0:    ctrl.lsu_opt = LSU_SB;
                    3'd1:    ctrl.lsu_opt = LSU_SH;
                    default: ctrl.lsu_opt = LSU_SW;
                endcase
            end
`ifdef CU_SYSTEM_NOP_EN
            // NOP: defaults leave reg_adr = 0, so WB suppresses the write
            OPC_MISC_MEM, OPC_SYSTEM: begin
                ctrl.kind = KIND_WB;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// Purpose : multi-cycle RV32I control unit, FETCH/DECODE/EXEC/MEM/WB sequencer with sticky TRAP.
// Latency : accept -> WRITE_ENB 3 cycles (ALU/LUI/AUIPC/JAL/JALR), 3 + MEM wait cycles for loads.
// Backpr. : INST_READY only in FETCH; MEM holds MEM_REQ until MEM_DONE or timeout trap.
// Ports   : CLK/RST (async active-high); MEM_INST/INST_VALID/INST_READY fetch handshake;
//           MEM_REQ/MEM_DONE LSU handshake; *_ADR, *_OPT, IMM_TYPE, *_MUX_SELECT datapath controls;
//           WRITE_ENB, MEM_WRITE_ENB, PC_EN strobes; TRAP sticky fault; STATE debug.
// Build   : CU_SYSTEM_NOP_EN (see cu_decode) turns FENCE/SYSTEM into NOPs.
// All outputs come straight from flops: each transition loads the values of the state being entered.
module cu_fsm
    import cu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RADR_W    = 5,
    parameter int TIMEOUT_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [XLEN-1:0]   MEM_INST,
    input  logic              INST_VALID,
    output logic              INST_READY,
    input  logic              MEM_DONE,
    output logic              MEM_REQ,
    output logic [RADR_W-1:0] RS1_ADR,
    output logic [RADR_W-1:0] RS2_ADR,
    output logic [RADR_W-1:0] REG_ADR,
    output logic [3:0]        ALU_OPT,
    output logic [3:0]        BR_OPT,
    output logic [2:0]        LSU_OPT,
    output logic [2:0]        IMM_TYPE,
    output logic [2:0]        RS1_MUX_SELECT,
    output logic [2:0]        RS2_MUX_SELECT,
    output logic [2:0]        REG_MUX_SELECT,
    output logic [2:0]        LSU_MUX_SELECT,
    output logic [2:0]        PC_MUX_SELECT,
    output logic              WRITE_ENB,
    output logic              MEM_WRITE_ENB,
    output logic              PC_EN,
    output logic              TRAP,
    output logic [2:0]        STATE
);

    // Last idle count before the counter reaches 2^TIMEOUT_W-1
    localparam logic [TIMEOUT_W-1:0] TCNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [2:0]           state;
    logic [XLEN-1:0]      ir;
    cu_ctrl_t             ctrl_q;
    cu_ctrl_t             dec_ctrl;
    logic                 dec_illegal;
    logic [TIMEOUT_W-1:0] tcnt;
    logic                 inst_ready;
    logic                 mem_req;
    logic                 mem_write_enb;
    logic                 write_enb;
    logic                 pc_en;
    logic                 trap;

    cu_decode u_decode (
        .ir      (ir),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_FETCH;
            ir            <= '0;
            ctrl_q        <= '0;
            ctrl_q.br_opt <= BR_NONE;
            tcnt          <= '0;
            inst_ready    <= 1'b0;
            mem_req       <= 1'b0;
            mem_write_enb <= 1'b0;
            write_enb     <= 1'b0;
            pc_en         <= 1'b0;
            trap          <= 1'b0;
        end else begin
            // Single-cycle strobes fall by default
            write_enb <= 1'b0;
            pc_en     <= 1'b0;
            case (state)
                ST_FETCH: begin
                    inst_ready <= 1'b1;
                    if (INST_VALID && inst_ready) begin
                        ir         <= MEM_INST;
                        inst_ready <= 1'b0;
                        state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ctrl_q <= dec_ctrl;
                    if (dec_illegal) begin
                        trap  <= 1'b1;
                        state <= ST_TRAP;
                    end else begin
                        // Conditional branches update the PC during EXEC itself
                        pc_en <= (dec_ctrl.kind == KIND_BR);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (ctrl_q.kind)
                        KIND_BR: begin
                            inst_ready <= 1'b1;
                            state      <= ST_FETCH;
                        end
                        KIND_LD: begin
                            mem_req <= 1'b1;
                            state   <= ST_MEM;
                        end
                        KIND_ST: begin
                            mem_req       <= 1'b1;
                            mem_write_enb <= 1'b1;
                            state         <= ST_MEM;
                        end
                        default: begin
                            write_enb <= (ctrl_q.reg_adr != 5'd0);
                            pc_en     <= 1'b1;
                            state     <= ST_WB;
                        end
                    endcase
                end
                ST_MEM: begin
                    // Done is checked first so it wins against the terminal count
                    if (MEM_DONE) begin
                        mem_req       <= 1'b0;
                        mem_write_enb <= 1'b0;
                        tcnt          <= '0;
                        pc_en         <= 1'b1;
                        if (ctrl_q.kind == KIND_ST) begin
                            inst_ready <= 1'b1;
                            state      <= ST_FETCH;
                        end else begin
                            write_enb <= (ctrl_q.reg_adr != 5'd0);
                            state     <= ST_WB;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == TCNT_LAST) begin
                            mem_req       <= 1'b0;
                            mem_write_enb <= 1'b0;
                            trap          <= 1'b1;
                            state         <= ST_TRAP;
                        end
                    end
                end
                ST_WB: begin
                    inst_ready <= 1'b1;
                    state      <= ST_FETCH;
                end
                ST_TRAP: begin
                    // Sticky until RST
                    inst_ready <= 1'b0;
                end
                default: begin
                    trap       <= 1'b1;
                    inst_ready <= 1'b0;
                    state      <= ST_TRAP;
                end
            endcase
        end
    end

    assign INST_READY     = inst_ready;
    assign MEM_REQ        = mem_req;
    assign RS1_ADR        = ctrl_q.rs1_adr;
    assign RS2_ADR        = ctrl_q.rs2_adr;
    assign REG_ADR        = ctrl_q.reg_adr;
    assign ALU_OPT        = ctrl_q.alu_opt;
    assign BR_OPT         = ctrl_q.br_opt;
    assign LSU_OPT        = ctrl_q.lsu_opt;
    assign IMM_TYPE       = ctrl_q.imm_type;
    assign RS1_MUX_SELECT = ctrl_q.rs1_mux;
    assign RS2_MUX_SELECT = ctrl_q.rs2_mux;
    assign REG_MUX_SELECT = ctrl_q.reg_mux;
    assign LSU_MUX_SELECT = ctrl_q.lsu_mux;
    assign PC_MUX_SELECT  = ctrl_q.pc_mux;
    assign WRITE_ENB      = write_enb;
    assign MEM_WRITE_ENB  = mem_write_enb;
    assign PC_EN          = pc_en;
    assign TRAP           = trap;
    assign STATE          = state;

endmodule

// File: tb/tb_cu_fsm.sv
// Purpose : directed self-checking bench for cu_fsm (honours CU_SYSTEM_NOP_EN for the FENCE case).
// Latency : cycle counts below are measured from the handshake-accept edge (cycle 0 = accept cycle).
// Backpr. : bench drives INST_VALID/MEM_DONE directly; every wait is bounded.
module tb_cu_fsm;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] MEM_INST = '0;
    logic        INST_VALID = 1'b0;
    logic        INST_READY;
    logic        MEM_DONE = 1'b0;
    logic        MEM_REQ;
    logic [4:0]  RS1_ADR, RS2_ADR, REG_ADR;
    logic [3:0]  ALU_OPT, BR_OPT;
    logic [2:0]  LSU_OPT, IMM_TYPE;
    logic [2:0]  RS1_MUX_SELECT, RS2_MUX_SELECT, REG_MUX_SELECT, LSU_MUX_SELECT, PC_MUX_SELECT;
    logic        WRITE_ENB, MEM_WRITE_ENB, PC_EN, TRAP;
    logic [2:0]  STATE;

    int checks = 0;
    int failures = 0;

    cu_fsm dut (
        .CLK(CLK), .RST(RST), .MEM_INST(MEM_INST), .INST_VALID(INST_VALID), .INST_READY(INST_READY),
        .MEM_DONE(MEM_DONE), .MEM_REQ(MEM_REQ), .RS1_ADR(RS1_ADR), .RS2_ADR(RS2_ADR), .REG_ADR(REG_ADR),
        .ALU_OPT(ALU_OPT), .BR_OPT(BR_OPT), .LSU_OPT(LSU_OPT), .IMM_TYPE(IMM_TYPE),
        .RS1_MUX_SELECT(RS1_MUX_SELECT), .RS2_MUX_SELECT(RS2_MUX_SELECT), .REG_MUX_SELECT(REG_MUX_SELECT),
        .LSU_MUX_SELECT(LSU_MUX_SELECT), .PC_MUX_SELECT(PC_MUX_SELECT), .WRITE_ENB(WRITE_ENB),
        .MEM_WRITE_ENB(MEM_WRITE_ENB), .PC_EN(PC_EN), .TRAP(TRAP), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; INST_VALID = 1'b0; MEM_DONE = 1'b0; MEM_INST = '0;
        tick(); tick();
        RST = 1'b0;
    endtask

    // Waits (bounded) for INST_READY, then presents one instruction for a single cycle.
    // Returns in cycle 1 (DECODE) relative to the accept.
    task automatic issue(input logic [31:0] inst);
        int n = 0;
        while (INST_READY !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (INST_READY !== 1'b1) begin failures++; $display("FAIL issue_ready inst=%h got=%b exp=1", inst, INST_READY); end
        MEM_INST = inst; INST_VALID = 1'b1;
        tick();
        INST_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; #2;
        checks++; if (STATE !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", STATE); end
        checks++; if (BR_OPT !== 4'd15) begin failures++; $display("FAIL reset_br_opt got=%0d exp=15", BR_OPT); end
        checks++; if ({ALU_OPT, LSU_OPT, IMM_TYPE, REG_ADR, RS2_MUX_SELECT} !== 18'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {ALU_OPT, LSU_OPT, IMM_TYPE, REG_ADR, RS2_MUX_SELECT}); end
        checks++; if ({INST_READY, MEM_REQ, WRITE_ENB, MEM_WRITE_ENB, PC_EN, TRAP} !== 6'd0) begin failures++; $display("FAIL reset_strobes got=%b exp=000000", {INST_READY, MEM_REQ, WRITE_ENB, MEM_WRITE_ENB, PC_EN, TRAP}); end
        tick();
        RST = 1'b0;
        tick();
        checks++; if (INST_READY !== 1'b1 || STATE !== 3'd0) begin failures++; $display("FAIL post_reset_ready got=%b/%0d exp=1/0", INST_READY, STATE); end
    endtask

    task automatic test_addi();
        do_reset();
        issue(32'h00500093);
        // Hold VALID with an illegal word outside FETCH: it must be ignored
        MEM_INST = 32'h0; INST_VALID = 1'b1;
        checks++; if (STATE !== 3'd1 || INST_READY !== 1'b0) begin failures++; $display("FAIL addi_c1 got=%0d/%b exp=1/0", STATE, INST_READY); end
        tick();
        checks++; if (STATE !== 3'd2 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL addi_c2 got=%0d/%b exp=2/0", STATE, WRITE_ENB); end
        tick();
        INST_VALID = 1'b0;
        checks++; if (STATE !== 3'd4 || ALU_OPT !== 4'd0 || RS2_MUX_SELECT !== 3'd1 || REG_ADR !== 5'd1) begin failures++; $display("FAIL addi_c3_fields got=%0d/%0d/%0d/%0d exp=4/0/1/1", STATE, ALU_OPT, RS2_MUX_SELECT, REG_ADR); end
        checks++; if (WRITE_ENB !== 1'b1 || PC_EN !== 1'b1 || TRAP !== 1'b0) begin failures++; $display("FAIL addi_c3_strobes got=%b%b%b exp=110", WRITE_ENB, PC_EN, TRAP); end
        tick();
        checks++; if (STATE !== 3'd0 || WRITE_ENB !== 1'b0 || PC_EN !== 1'b0 || INST_READY !== 1'b1) begin failures++; $display("FAIL addi_c4 got=%0d/%b%b%b exp=0/001", STATE, WRITE_ENB, PC_EN, INST_READY); end
    endtask

    task automatic test_load();
        int req_cycles = 0;
        do_reset();
        issue(32'h0040A103);
        tick();
        checks++; if (LSU_OPT !== 3'd2 || REG_MUX_SELECT !== 3'd1 || STATE !== 3'd2) begin failures++; $display("FAIL lw_exec got=%0d/%0d/%0d exp=2/1/2", LSU_OPT, REG_MUX_SELECT, STATE); end
        tick();
        for (int k = 0; k < 3; k++) begin
            if (MEM_REQ === 1'b1 && MEM_WRITE_ENB === 1'b0 && STATE === 3'd3) req_cycles++;
            if (k == 2) MEM_DONE = 1'b1;
            tick();
        end
        MEM_DONE = 1'b0;
        checks++; if (req_cycles != 3) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=3", req_cycles); end
        checks++; if (STATE !== 3'd4 || WRITE_ENB !== 1'b1 || REG_ADR !== 5'd2 || MEM_REQ !== 1'b0 || PC_EN !== 1'b1) begin failures++; $display("FAIL lw_wb got=%0d/%b/%0d/%b/%b exp=4/1/2/0/1", STATE, WRITE_ENB, REG_ADR, MEM_REQ, PC_EN); end
        tick();
        checks++; if (STATE !== 3'd0 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL lw_done got=%0d/%b exp=0/0", STATE, WRITE_ENB); end
    endtask

    task automatic test_store_timeout();
        int n = 0;
        int bad = 0;
        do_reset();
        issue(32'h0020A423);
        tick();
        checks++; if (LSU_OPT !== 3'd7 || STATE !== 3'd2) begin failures++; $display("FAIL sw_exec got=%0d/%0d exp=7/2", LSU_OPT, STATE); end
        tick();
        while (STATE === 3'd3 && n < 400) begin
            if (MEM_REQ !== 1'b1 || MEM_WRITE_ENB !== 1'b1 || TRAP !== 1'b0) bad++;
            n++;
            tick();
        end
        checks++; if (n != 255) begin failures++; $display("FAIL sw_timeout_cycles got=%0d exp=255", n); end
        checks++; if (bad != 0) begin failures++; $display("FAIL sw_mem_strobes bad_cycles got=%0d exp=0", bad); end
        checks++; if (TRAP !== 1'b1 || STATE !== 3'd5 || MEM_REQ !== 1'b0 || MEM_WRITE_ENB !== 1'b0 || INST_READY !== 1'b0) begin failures++; $display("FAIL sw_trap got=%b/%0d/%b%b%b exp=1/5/000", TRAP, STATE, MEM_REQ, MEM_WRITE_ENB, INST_READY); end
        MEM_INST = 32'h00500093; INST_VALID = 1'b1;
        repeat (10) tick();
        INST_VALID = 1'b0;
        checks++; if (TRAP !== 1'b1 || STATE !== 3'd5 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL sw_trap_held got=%b/%0d/%b exp=1/5/0", TRAP, STATE, WRITE_ENB); end
    endtask

    task automatic test_done_wins();
        do_reset();
        issue(32'h0020A423);
        tick(); tick();
        repeat (254) tick();
        checks++; if (STATE !== 3'd3 || TRAP !== 1'b0) begin failures++; $display("FAIL tc_before got=%0d/%b exp=3/0", STATE, TRAP); end
        MEM_DONE = 1'b1;
        tick();
        MEM_DONE = 1'b0;
        checks++; if (STATE !== 3'd0 || TRAP !== 1'b0 || PC_EN !== 1'b1 || MEM_REQ !== 1'b0 || MEM_WRITE_ENB !== 1'b0) begin failures++; $display("FAIL tc_done_wins got=%0d/%b/%b/%b%b exp=0/0/1/00", STATE, TRAP, PC_EN, MEM_REQ, MEM_WRITE_ENB); end
        // Counter must have been cleared: a second long wait must not trap early
        issue(32'h0020A423);
        tick(); tick();
        repeat (200) tick();
        MEM_DONE = 1'b1;
        tick();
        MEM_DONE = 1'b0;
        checks++; if (STATE !== 3'd0 || TRAP !== 1'b0) begin failures++; $display("FAIL tc_cleared got=%0d/%b exp=0/0", STATE, TRAP); end
    endtask

    task automatic test_branch();
        do_reset();
        issue(32'h00000463);
        checks++; if (PC_EN !== 1'b0) begin failures++; $display("FAIL beq_decode_pc got=%b exp=0", PC_EN); end
        tick();
        checks++; if (STATE !== 3'd2 || BR_OPT !== 4'd0 || IMM_TYPE !== 3'd1 || PC_EN !== 1'b1 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL beq_exec got=%0d/%0d/%0d/%b/%b exp=2/0/1/1/0", STATE, BR_OPT, IMM_TYPE, PC_EN, WRITE_ENB); end
        tick();
        checks++; if (STATE !== 3'd0 || PC_EN !== 1'b0 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL beq_fetch got=%0d/%b/%b exp=0/0/0", STATE, PC_EN, WRITE_ENB); end
    endtask

    task automatic test_x0_and_illegal();
        do_reset();
        issue(32'h00208033);
        tick(); tick();
        checks++; if (STATE !== 3'd4 || WRITE_ENB !== 1'b0 || PC_EN !== 1'b1 || RS1_ADR !== 5'd1 || RS2_ADR !== 5'd2 || REG_ADR !== 5'd0) begin failures++; $display("FAIL add_x0 got=%0d/%b/%b/%0d/%0d/%0d exp=4/0/1/1/2/0", STATE, WRITE_ENB, PC_EN, RS1_ADR, RS2_ADR, REG_ADR); end
        issue(32'h00000000);
        tick();
        checks++; if (TRAP !== 1'b1 || STATE !== 3'd5 || INST_READY !== 1'b0) begin failures++; $display("FAIL zero_trap got=%b/%0d/%b exp=1/5/0", TRAP, STATE, INST_READY); end
        // Async clear mid-cycle, away from any clock edge
        #2 RST = 1'b1; #1;
        checks++; if (TRAP !== 1'b0 || STATE !== 3'd0) begin failures++; $display("FAIL trap_rst_clear got=%b/%0d exp=0/0", TRAP, STATE); end
        tick();
        RST = 1'b0;
        // funct7 = 0x01 on ADD is not RV32I
        issue(32'h022081B3);
        tick();
        checks++; if (TRAP !== 1'b1 || STATE !== 3'd5) begin failures++; $display("FAIL bad_funct7 got=%b/%0d exp=1/5", TRAP, STATE); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(32'h402081B3);  // SUB x3,x1,x2
        tick(); tick();
        checks++; if (ALU_OPT !== 4'd1 || WRITE_ENB !== 1'b1 || REG_ADR !== 5'd3) begin failures++; $display("FAIL sub got=%0d/%b/%0d exp=1/1/3", ALU_OPT, WRITE_ENB, REG_ADR); end
        issue(32'h4020D1B3);  // SRA x3,x1,x2
        tick(); tick();
        checks++; if (ALU_OPT !== 4'd7 || WRITE_ENB !== 1'b1 || TRAP !== 1'b0) begin failures++; $display("FAIL sra got=%0d/%b/%b exp=7/1/0", ALU_OPT, WRITE_ENB, TRAP); end
        issue(32'h010000EF);  // JAL x1,+16
        tick(); tick();
        checks++; if (BR_OPT !== 4'd4 || IMM_TYPE !== 3'd4 || REG_MUX_SELECT !== 3'd2 || WRITE_ENB !== 1'b1 || REG_ADR !== 5'd1) begin failures++; $display("FAIL jal got=%0d/%0d/%0d/%b/%0d exp=4/4/2/1/1", BR_OPT, IMM_TYPE, REG_MUX_SELECT, WRITE_ENB, REG_ADR); end
        issue(32'h000012B7);  // LUI x5,1
        tick(); tick();
        checks++; if (IMM_TYPE !== 3'd3 || RS1_MUX_SELECT !== 3'd2 || BR_OPT !== 4'd15 || WRITE_ENB !== 1'b1 || REG_ADR !== 5'd5) begin failures++; $display("FAIL lui got=%0d/%0d/%0d/%b/%0d exp=3/2/15/1/5", IMM_TYPE, RS1_MUX_SELECT, BR_OPT, WRITE_ENB, REG_ADR); end
    endtask

    task automatic test_fence();
        do_reset();
        issue(32'h0000000F);
        tick();
`ifdef CU_SYSTEM_NOP_EN
        checks++; if (STATE !== 3'd2 || TRAP !== 1'b0) begin failures++; $display("FAIL fence_exec got=%0d/%b exp=2/0", STATE, TRAP); end
        tick();
        checks++; if (STATE !== 3'd4 || PC_EN !== 1'b1 || WRITE_ENB !== 1'b0 || TRAP !== 1'b0) begin failures++; $display("FAIL fence_nop got=%0d/%b/%b/%b exp=4/1/0/0", STATE, PC_EN, WRITE_ENB, TRAP); end
`else
        checks++; if (STATE !== 3'd5 || TRAP !== 1'b1) begin failures++; $display("FAIL fence_trap got=%0d/%b exp=5/1", STATE, TRAP); end
`endif
    endtask

    task automatic test_async_reset_mem();
        do_reset();
        issue(32'h0040A103);
        tick(); tick(); tick();
        checks++; if (STATE !== 3'd3 || MEM_REQ !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0d/%b exp=3/1", STATE, MEM_REQ); end
        #3 RST = 1'b1; #1;
        checks++; if (STATE !== 3'd0 || MEM_REQ !== 1'b0 || TRAP !== 1'b0 || BR_OPT !== 4'd15 || LSU_OPT !== 3'd0 || REG_MUX_SELECT !== 3'd0) begin failures++; $display("FAIL arst_mem got=%0d/%b/%b/%0d/%0d/%0d exp=0/0/0/15/0/0", STATE, MEM_REQ, TRAP, BR_OPT, LSU_OPT, REG_MUX_SELECT); end
        MEM_DONE = 1'b1;
        tick();
        checks++; if (WRITE_ENB !== 1'b0 || PC_EN !== 1'b0) begin failures++; $display("FAIL arst_no_write got=%b/%b exp=0/0", WRITE_ENB, PC_EN); end
        MEM_DONE = 1'b0;
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store_timeout();
        test_done_wins();
        test_branch();
        test_x0_and_illegal();
        test_back_to_back();
        test_fence();
        test_async_reset_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
